// File: rtl/ifu_fetch_if.sv
// Instruction-fetch bus bundle: memory request/response channel, the
// instruction buffer toward decode, and the redirect/halt controls from execute.
interface ifu_fetch_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;

    // Fetch unit side
    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready, redirect_valid, redirect_pc, halt
    );

    // Memory / decode / execute side
    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready, redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one memory read at a time and
// delivers each word (with PC and fault flag) through a one-entry buffer.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    ifu_fetch_if.master  io_bus
);
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_M1 = TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic        r_pending;
    logic [31:0] r_timer;
    logic        r_req_valid;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [63:0] r_inst_pc;
    logic        r_inst_fault;

    logic        w_req_hs;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_resp;
    logic [63:0] w_pc_next;

    assign w_req_hs     = r_req_valid & io_bus.mem_req_ready;
    assign w_misaligned = |r_pc[1:0];
    assign w_timeout    = TIMEOUT_EN && (r_timer == TIMEOUT_M1);
    assign w_resp       = io_bus.mem_resp_valid;
    assign w_pc_next    = r_pc + 64'd4;

    // Fetch FSM with registered request and instruction-buffer outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_pending    <= 1'b0;
            r_timer      <= '0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_fault <= 1'b0;
        end else if (io_bus.redirect_valid) begin
            // Redirect overrides everything; the buffered word is dropped and
            // any response arriving this cycle is thrown away.
            r_pc         <= io_bus.redirect_pc;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b0;
            r_timer      <= '0;
            if ((r_pending && !w_resp) || w_req_hs) begin
                r_pending <= 1'b1;
                r_state   <= S_DRAIN;
            end else begin
                r_pending <= 1'b0;
                r_state   <= S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_req_valid) begin
                        // A presented request is held until accepted
                        if (io_bus.mem_req_ready) begin
                            r_req_valid <= 1'b0;
                            r_pending   <= 1'b1;
                            r_timer     <= '0;
                            r_state     <= S_WAIT;
                        end
                    end else if (io_bus.halt) begin
                        r_state <= S_HALTED;
                    end else if (w_misaligned) begin
                        r_inst       <= '0;
                        r_inst_fault <= 1'b1;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_req_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 32'd1;
                    if (w_resp) begin
                        r_pending    <= 1'b0;
                        r_inst       <= io_bus.mem_resp_err ? 32'd0 : io_bus.mem_resp_data;
                        r_inst_fault <= io_bus.mem_resp_err;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end else if (w_timeout) begin
                        // Request stays outstanding; its late response is drained later
                        r_inst       <= '0;
                        r_inst_fault <= 1'b1;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_resp) begin
                        r_pending <= 1'b0;
                    end
                    if (io_bus.inst_ready) begin
                        r_inst_valid <= 1'b0;
                        if (r_inst_fault || io_bus.halt) begin
                            r_state <= S_HALTED;
                        end else begin
                            r_pc <= w_pc_next;
                            if (r_pending && !w_resp) begin
                                r_state <= S_DRAIN;
                            end else begin
                                // Successor of an aligned PC is aligned: request at once
                                r_req_valid <= 1'b1;
                                r_state     <= S_FETCH;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_resp || !r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (w_resp) begin
                        r_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign io_bus.mem_req_valid = r_req_valid;
    assign io_bus.mem_req_addr  = r_pc;
    assign io_bus.inst_valid    = r_inst_valid;
    assign io_bus.inst          = r_inst;
    assign io_bus.inst_pc       = r_inst_pc;
    assign io_bus.inst_fault    = r_inst_fault;
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: randomized memory/decode stimulus, queue-based scoreboard
// fed by a sequential-stream reference model, plus directed boundary cases.
module tb_ifu_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } item_t;

    logic clk;
    logic rst_n;
    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_consumed = 0;
    item_t       exp_q[$];
    logic [63:0] req_log[$];
    logic [63:0] err_addr  = '1;
    logic [63:0] slow_addr = '1;
    int          force_lat = 0;
    bit          ready_rand = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        return a[33:2] ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: sequential stream from start, ending at the first fault
    task automatic push_stream(input logic [63:0] start, input int n, output int cnt);
        logic [63:0] a;
        item_t it;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            a = start + 64'(4 * k);
            cnt++;
            it.pc = a;
            if (a[1:0] != 2'b00 || a == err_addr || a == slow_addr) begin
                it.inst  = '0;
                it.fault = 1'b1;
                exp_q.push_back(it);
                break;
            end
            it.inst  = mem_data(a);
            it.fault = 1'b0;
            exp_q.push_back(it);
        end
    endtask

    // Memory responder: random ready, one response per accepted request
    initial begin : responder
        logic        s_hs;
        logic [63:0] s_addr;
        logic [63:0] m_addr;
        int          m_cnt;
        bit          m_active;
        m_active = 0;
        m_cnt    = 0;
        m_addr   = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            s_hs   = rst_n && bus.mem_req_valid && bus.mem_req_ready;
            s_addr = bus.mem_req_addr;
            @(posedge clk);
            #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_err   = 1'b0;
            bus.mem_resp_data  = '0;
            if (!rst_n) begin
                m_active = 0;
                s_hs     = 1'b0;
            end
            if (s_hs) begin
                req_log.push_back(s_addr);
                m_addr   = s_addr;
                m_active = 1;
                if (s_addr == slow_addr) m_cnt = 9;
                else if (force_lat != 0) m_cnt = force_lat;
                else m_cnt = $urandom_range(1, 4);
            end
            if (m_active) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_active           = 0;
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = mem_data(m_addr);
                    bus.mem_resp_err   = (m_addr == err_addr);
                end
            end
            bus.mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops on every decode handshake, plus protocol checks
    initial begin : monitor
        logic        p_ivalid, p_iready, p_redir, p_rvalid, p_rready, p_ifault;
        logic [31:0] p_inst;
        logic [63:0] p_ipc, p_raddr;
        item_t       e;
        p_ivalid = 0; p_iready = 0; p_redir = 0; p_rvalid = 0; p_rready = 0; p_ifault = 0;
        p_inst = '0; p_ipc = '0; p_raddr = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (p_ivalid && !p_iready && !p_redir)
                    chk("buffer_stable", 64'({bus.inst_valid, bus.inst == p_inst, bus.inst_pc == p_ipc,
                                              bus.inst_fault == p_ifault}), 64'hF);
                if (p_rvalid && !p_rready && !p_redir)
                    chk("req_held", 64'({bus.mem_req_valid, bus.mem_req_addr == p_raddr}), 64'h3);
                if (bus.mem_req_valid)
                    chk("req_aligned", 64'(bus.mem_req_addr[1:0]), 64'h0);
                if (bus.inst_valid && bus.inst_ready) begin
                    chk("inst_expected", 64'(exp_q.size() != 0), 64'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("inst_word", 64'(bus.inst), 64'(e.inst));
                        chk("inst_pc", bus.inst_pc, e.pc);
                        chk("inst_fault", 64'(bus.inst_fault), 64'(e.fault));
                    end
                    n_consumed++;
                end
                p_ivalid = bus.inst_valid; p_iready = bus.inst_ready; p_redir = bus.redirect_valid;
                p_rvalid = bus.mem_req_valid; p_rready = bus.mem_req_ready;
                p_inst = bus.inst; p_ipc = bus.inst_pc; p_ifault = bus.inst_fault;
                p_raddr = bus.mem_req_addr;
            end else begin
                p_ivalid = 0; p_rvalid = 0; p_redir = 0;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'h0);
        chk({tag, "_req_addr"}, bus.mem_req_addr, RESET_PC);
        chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'h0);
        chk({tag, "_inst"}, 64'(bus.inst), 64'h0);
        chk({tag, "_inst_pc"}, bus.inst_pc, 64'h0);
        chk({tag, "_inst_fault"}, 64'(bus.inst_fault), 64'h0);
    endtask

    task automatic consume_to(input int goal, input bit rnd);
        int guard;
        guard = 0;
        while (n_consumed < goal && guard < 600) begin
            bus.inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #2;
            guard++;
        end
        bus.inst_ready = 1'b0;
        chk("consume_goal", 64'(n_consumed), 64'(goal));
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic run_phase(input logic [63:0] tgt, input int n, input bit rnd);
        int c;
        int goal;
        push_stream(tgt, n, c);
        goal = n_consumed + c;
        redirect_to(tgt);
        consume_to(goal, rnd);
    endtask

    task automatic wait_ivalid();
        int guard;
        guard = 0;
        while (!bus.inst_valid && guard < 60) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk("wait_inst_valid", 64'(bus.inst_valid), 64'h1);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int   n0;
        logic busy;
        n0   = req_log.size();
        busy = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #2;
            busy = busy | bus.mem_req_valid | bus.inst_valid;
        end
        chk(name, 64'({busy, req_log.size() != n0}), 64'h0);
    endtask

    task automatic wait_new_req(input int n0);
        int guard;
        guard = 0;
        while (req_log.size() <= n0 && guard < 60) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk("new_request_seen", 64'(req_log.size() > n0), 64'h1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          c;
        int          cyc;
        int          n0;
        logic        stable;
        logic [63:0] tgt;
        int          n;

        rst_n              = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset");

        // First two fetches after reset, fixed 1-cycle memory
        force_lat = 1;
        push_stream(RESET_PC, 2, c);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!bus.inst_valid && cyc < 20) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        chk("first_valid_latency", 64'(cyc), 64'd3);
        consume_to(2, 0);
        chk("req_log_len", 64'(req_log.size() >= 2), 64'h1);
        if (req_log.size() >= 2) begin
            chk("first_req_addr", req_log[0], 64'h8000_0000);
            chk("second_req_addr", req_log[1], 64'h8000_0004);
        end
        force_lat = 0;

        // Buffer held by decode for 5 cycles
        wait_ivalid();
        n0     = req_log.size();
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #2;
            stable = stable & bus.inst_valid & (bus.inst_pc == 64'h8000_0008) &
                     (bus.inst == mem_data(64'h8000_0008)) & !bus.mem_req_valid;
        end
        chk("hold_5_cycles", 64'(stable), 64'h1);
        chk("hold_no_new_req", 64'(req_log.size()), 64'(n0));
        ready_rand = 1;
        push_stream(64'h8000_0008, 3, c);
        consume_to(n_consumed + c, 1);

        // Redirect while waiting; stale response lands 2 cycles later
        ready_rand = 0;
        wait_ivalid();
        push_stream(64'h8000_0014, 1, c);
        force_lat = 3;
        n0 = req_log.size();
        consume_to(n_consumed + 1, 0);
        wait_new_req(n0);
        force_lat = 0;
        err_addr  = 64'h8000_0108;
        push_stream(64'h8000_0100, 5, c);
        n0 = req_log.size();
        redirect_to(64'h8000_0100);
        consume_to(n_consumed + c, 1);
        chk("redirect_req_seen", 64'(req_log.size() > n0), 64'h1);
        if (req_log.size() > n0)
            chk("redirect_first_addr", req_log[n0], 64'h8000_0100);

        // Memory error halts fetch until a redirect
        check_quiet("halted_after_err", 10);
        err_addr   = '1;
        ready_rand = 1;
        run_phase(RESET_PC, 2, 1);

        // Misaligned redirect target faults without a request
        run_phase(64'h8000_0102, 3, 1);
        check_quiet("halted_after_misalign", 8);

        // Timeout, then resume while the late response may still be pending
        slow_addr = 64'h8000_0208;
        run_phase(64'h8000_0200, 5, 1);
        slow_addr = '1;
        run_phase(64'h8000_0300, 3, 1);

        // Halt sampled on the buffer handshake
        push_stream(64'h8000_0500, 1, c);
        redirect_to(64'h8000_0500);
        wait_ivalid();
        bus.halt = 1'b1;
        consume_to(n_consumed + 1, 0);
        bus.halt = 1'b0;
        check_quiet("halted_after_halt", 10);

        // Randomized phases
        for (int ph = 0; ph < 12; ph++) begin
            tgt = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
            if ($urandom_range(0, 7) == 0) tgt = tgt + 64'd2;
            n         = $urandom_range(1, 6);
            err_addr  = '1;
            slow_addr = '1;
            case ($urandom_range(0, 3))
                0: err_addr  = tgt + 64'($urandom_range(0, 5)) * 64'd4;
                1: slow_addr = tgt + 64'($urandom_range(0, 5)) * 64'd4;
                default: ;
            endcase
            ready_rand = ($urandom_range(0, 1) == 1);
            run_phase(tgt, n, 1);
        end
        err_addr  = '1;

        // Reset asserted mid-WAIT
        slow_addr  = 64'h8000_0400;
        ready_rand = 0;
        n0 = req_log.size();
        redirect_to(64'h8000_0400);
        wait_new_req(n0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("reset_in_wait");
        slow_addr = '1;
        repeat (2) @(posedge clk);
        push_stream(RESET_PC, 2, c);
        @(negedge clk);
        rst_n = 1'b1;
        consume_to(n_consumed + c, 1);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: the producer side of the 32-bit instruction interface that feeds the decode stage.
- Holds the 64-bit PC and issues one instruction-memory read at a time over a valid/ready request and valid-only response interface.
- Delivers each fetched word, with its PC and a fault flag, to decode through a one-entry valid/ready output buffer.
- Accepts redirects from execute (jal/jalr/branches) and a halt request (ebreak).

Parameters:
RESET_PC  64'h0000_0000_8000_0000  PC fetched first after reset
TIMEOUT  256  max cycles in WAIT before fault (0 = no timeout)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  64  fetch address (= pc)
mem_resp_valid  input  1  response valid, single cycle, no backpressure
mem_resp_data  input  32  fetched instruction word
mem_resp_err  input  1  access error on this response
inst_valid  output  1  instruction buffer valid toward decode
inst_ready  input  1  decode accepts instruction
inst  output  32  instruction word (0 when inst_fault)
inst_pc  output  64  PC of inst
inst_fault  output  1  fetch fault (misaligned PC, mem error, timeout)
redirect_valid  input  1  PC redirect, single cycle
redirect_pc  input  64  redirect target
halt  input  1  stop fetching (ebreak)

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, pending=0, timer=0.
- Output reset values: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0. mem_req_valid is registered/state-derived and first rises the cycle after rst_n releases.
- States:
  - FETCH: if halt, go to HALTED. Else if pc[1:0]!=0, load fault (inst=0, inst_fault=1, inst_pc=pc), go to HOLD, no memory request. Else drive mem_req_valid=1 with mem_req_addr=pc; addr stays stable and the request is never withdrawn until mem_req_ready. On handshake: pending=1, timer=0, go to WAIT.
  - WAIT: timer increments each cycle. On mem_resp_valid: pending=0; load inst=mem_resp_data (0 if err), inst_fault=mem_resp_err, inst_pc=pc; go to HOLD. If TIMEOUT!=0 and timer reaches TIMEOUT-1 with no response: load timeout fault, go to HOLD, pending stays 1.
  - HOLD: inst_valid=1, contents stable until inst_ready. On handshake: if inst_fault or halt, go to HALTED. Else pc<=pc+4 (64-bit wrap) and go to FETCH, or to DRAIN if pending=1.
  - DRAIN: mem_req_valid=0. Waits for the stale response, discards it, clears pending, then goes to FETCH.
  - HALTED: no requests, inst_valid=0. Left only by redirect or reset. A late response arriving in HALTED clears pending and is discarded.
- Redirect: allowed in any state and has priority over all other transitions that cycle.
  - pc<=redirect_pc and inst_valid drops the next cycle; the buffered instruction is discarded unless inst_ready is high in the same cycle (then it counts as consumed).
  - Next state is DRAIN if a request is outstanding. This includes a FETCH handshake in the same cycle and WAIT. Otherwise next state is FETCH.
  - A mem_resp_valid arriving in the redirect cycle is discarded.
  - A misaligned redirect_pc produces an alignment fault on the next FETCH.
- Never more than one outstanding request; a stale response is never delivered to decode.
- Latency: request handshake at cycle N, response at N+k gives inst_valid at N+k+1. Best-case throughput is 1 instruction per 3 cycles (FETCH, WAIT, HOLD).
- halt is level-sampled only in FETCH and on the HOLD handshake.

Test Plan:
- Reset, then memory with ready=1 and 1-cycle response returning 0x00000013,0x00100093 → mem_req_addr 0x80000000 then 0x80000004; inst_pc matches each; inst_valid first high 3 cycles after reset release.
- Hold inst_ready=0 for 5 cycles in HOLD → inst/inst_pc/inst_valid stable, no new mem_req_valid; pc advances only after handshake.
- redirect_valid with redirect_pc=0x80000100 while in WAIT, response 2 cycles later → response discarded, next request addr 0x80000100, no inst_valid for the stale word.
- mem_resp_err=1 → inst=0, inst_fault=1, inst_pc=faulting addr; after handshake no requests until redirect to 0x80000000 resumes fetch.
- redirect_pc=0x80000102 → inst_fault=1, inst_pc=0x80000102, mem_req_valid never asserted for it.
- TIMEOUT=4, memory silent then responds late → fault after 4 WAIT cycles; late response absorbed (DRAIN/HALTED); rst_n low mid-WAIT → all outputs at reset values immediately.
